// File: rtl/dmem_arbiter_if.sv
// Debug/loader master port of the data-memory arbiter.
// Handshake: a beat transfers on a clock edge where dbg_req && dbg_gnt; the master
// holds dbg_we/lock/addr/wdata stable while dbg_req && !dbg_gnt. dbg_rvalid/dbg_rdata
// return read data one cycle after a granted read, with no back-pressure.
interface dmem_arbiter_if #(
    parameter int AW = 11
) ();
    logic          dbg_req;
    logic          dbg_we;
    logic          dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [31:0]   dbg_rdata;

    modport master (
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU (default priority) and a debug
// master that wins on idle CPU cycles, after a starvation window, or while it holds a burst.
module dmem_arbiter #(
    parameter int AW           = 11,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_dm_ena,
    input  logic             cpu_dm_wena,
    input  logic [31:0]      cpu_dm_addr,
    input  logic [31:0]      cpu_dm_wdata,
    output logic [31:0]      cpu_dm_rdata,
    output logic             cpu_stall,
    dmem_arbiter_if.slave    dbg,
    output logic             mem_ena,
    output logic             mem_wena,
    output logic [AW-1:0]    mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    // Arbiter state: 0 CPU_OWN, 1 DBG_BURST, 2 FORCE_CPU
    output logic [1:0]       state_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        CPU_OWN   = 2'd0,
        DBG_BURST = 2'd1,
        FORCE_CPU = 2'd2
    } state_e;

    state_e        state_q;
    logic [SW-1:0] starve_q;
    logic [BW-1:0] burst_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic          dbg_win;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_dm_addr[31:AW+2], cpu_dm_addr[1:0]};

    always_comb begin
        dbg_win = 1'b0;
        if (!rst) begin
            case (state_q)
                CPU_OWN:   dbg_win = dbg.dbg_req && (!cpu_dm_ena || starve_q == STARVE_MAX);
                DBG_BURST: dbg_win = dbg.dbg_req;
                default:   dbg_win = 1'b0;
            endcase
        end
    end

    // Everything combinational is forced to zero while reset is held.
    assign dbg.dbg_gnt    = dbg_win;
    assign cpu_stall      = dbg_win && cpu_dm_ena;
    assign mem_ena        = !rst && (dbg_win || cpu_dm_ena);
    assign mem_wena       = rst ? 1'b0 : (dbg_win ? dbg.dbg_we : cpu_dm_wena);
    assign mem_addr       = rst ? '0 : (dbg_win ? dbg.dbg_addr : cpu_dm_addr[AW+1:2]);
    assign mem_wdata      = rst ? '0 : (dbg_win ? dbg.dbg_wdata : cpu_dm_wdata);
    assign cpu_dm_rdata   = rst ? '0 : mem_rdata;
    assign dbg.dbg_rvalid = rvalid_q && !rst;
    // Read data is live from memory in the return cycle, then held for the master.
    assign dbg.dbg_rdata  = rst ? '0 : (rvalid_q ? mem_rdata : rdata_q);
    assign state_o        = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CPU_OWN;
            starve_q <= '0;
            burst_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= dbg_win && !dbg.dbg_we;
            if (rvalid_q) rdata_q <= mem_rdata;

            if (dbg_win) begin
                starve_q <= '0;
            end else if (dbg.dbg_req && cpu_dm_ena) begin
                if (starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
            end else begin
                starve_q <= '0;
            end

            case (state_q)
                CPU_OWN: begin
                    if (dbg_win && dbg.dbg_lock) begin
                        if (MAX_BURST == 1) begin
                            state_q <= FORCE_CPU;
                        end else begin
                            state_q <= DBG_BURST;
                            burst_q <= BW'(1);
                        end
                    end
                end
                DBG_BURST: begin
                    if (dbg_win && dbg.dbg_lock) begin
                        if (burst_q == BURST_LAST) begin
                            state_q <= FORCE_CPU;
                            burst_q <= '0;
                        end else begin
                            burst_q <= burst_q + 1'b1;
                        end
                    end else begin
                        state_q <= CPU_OWN;
                        burst_q <= '0;
                    end
                end
                default: state_q <= CPU_OWN;
            endcase
        end
    end
endmodule
